// File: rtl/code_group_tx_pkg.sv
// Shared code-group constants and state encodings for the 1000BASE-X transmit path.
// The control and idle symbols are kept as {K flag, octet} pairs so the encoder sees one uniform input.
package code_group_tx_pkg;

  typedef enum logic [2:0] {
    IDLE_EVEN = 3'd0,
    IDLE_ODD  = 3'd1,
    SOP       = 3'd2,
    DATA      = 3'd3,
    EPD_T     = 3'd4,
    EPD_R1    = 3'd5,
    EPD_R2    = 3'd6
  } tx_state_t;

  typedef struct packed {
    logic       k;
    logic [7:0] octet;
  } cg_sym_t;

  localparam cg_sym_t SYM_K28_5 = '{k: 1'b1, octet: 8'hBC};
  localparam cg_sym_t SYM_K27_7 = '{k: 1'b1, octet: 8'hFB};
  localparam cg_sym_t SYM_K29_7 = '{k: 1'b1, octet: 8'hFD};
  localparam cg_sym_t SYM_K23_7 = '{k: 1'b1, octet: 8'hF7};
  localparam cg_sym_t SYM_D16_2 = '{k: 1'b0, octet: 8'h50};
  localparam cg_sym_t SYM_D5_6  = '{k: 1'b0, octet: 8'hC5};

  // K28.5 as sent from negative running disparity; this is also the reset value of the output.
  localparam logic [9:0] CG_K28_5_NEG = 10'b0011111010;

endpackage

// File: rtl/enc_8b10b.sv
// Combinational 8b/10b encoder: octet + K flag + running disparity in, abcdei_fghj group + new RD out.
// RD is 1 for RD+. Only the K codes legal in 8b/10b (K28.y, K23/27/29/30.7) are meaningful with k=1.
module enc_8b10b (
  input  logic [7:0] octet,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] six_neg;
  logic [5:0] six;
  logic       six_unbal;
  logic       rd_mid;
  logic [3:0] four_neg;
  logic [3:0] four;
  logic       four_unbal;
  logic       use_a7;
  logic       k28_bal;

  assign x = octet[4:0];
  assign y = octet[7:5];

  // NOTE: every signal driven here gets a default first, so no path through the block can infer a latch.
  always_comb begin
    six_neg = 6'b000000;
    case (x)
      5'd0:  six_neg = 6'b100111;
      5'd1:  six_neg = 6'b011101;
      5'd2:  six_neg = 6'b101101;
      5'd3:  six_neg = 6'b110001;
      5'd4:  six_neg = 6'b110101;
      5'd5:  six_neg = 6'b101001;
      5'd6:  six_neg = 6'b011001;
      5'd7:  six_neg = 6'b111000;
      5'd8:  six_neg = 6'b111001;
      5'd9:  six_neg = 6'b100101;
      5'd10: six_neg = 6'b010101;
      5'd11: six_neg = 6'b110100;
      5'd12: six_neg = 6'b001101;
      5'd13: six_neg = 6'b101100;
      5'd14: six_neg = 6'b011100;
      5'd15: six_neg = 6'b010111;
      5'd16: six_neg = 6'b011011;
      5'd17: six_neg = 6'b100011;
      5'd18: six_neg = 6'b010011;
      5'd19: six_neg = 6'b110010;
      5'd20: six_neg = 6'b001011;
      5'd21: six_neg = 6'b101010;
      5'd22: six_neg = 6'b011010;
      5'd23: six_neg = 6'b111010;
      5'd24: six_neg = 6'b110011;
      5'd25: six_neg = 6'b100110;
      5'd26: six_neg = 6'b010110;
      5'd27: six_neg = 6'b110110;
      5'd28: six_neg = k ? 6'b001111 : 6'b001110;
      5'd29: six_neg = 6'b101110;
      5'd30: six_neg = 6'b011110;
      5'd31: six_neg = 6'b101011;
      default: six_neg = 6'b000000;
    endcase

    // D.07 is balanced but still alternates with RD, like the unbalanced sub-blocks.
    six_unbal = ($countones(six_neg) != 3);
    six       = (rd_in && (six_unbal || (x == 5'd7))) ? ~six_neg : six_neg;
    rd_mid    = six_unbal ? ~rd_in : rd_in;

    // The alternate x.7 avoids a run of five equal bits across the sub-block boundary.
    use_a7 = (y == 3'd7) &&
             (k ||
              (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

    four_neg = 4'b0000;
    case (y)
      3'd0: four_neg = 4'b1011;
      3'd1: four_neg = 4'b1001;
      3'd2: four_neg = 4'b0101;
      3'd3: four_neg = 4'b1100;
      3'd4: four_neg = 4'b1101;
      3'd5: four_neg = 4'b1010;
      3'd6: four_neg = 4'b0110;
      3'd7: four_neg = use_a7 ? 4'b0111 : 4'b1110;
      default: four_neg = 4'b0000;
    endcase

    four_unbal = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);
    // K28 with a balanced y uses the complement of the data code to form the comma.
    k28_bal    = k && (x == 5'd28) &&
                 ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6));

    if (k28_bal)
      four = rd_mid ? four_neg : ~four_neg;
    else
      four = (rd_mid && (four_unbal || (y == 3'd3))) ? ~four_neg : four_neg;

    code   = {six, four};
    rd_out = four_unbal ? ~rd_mid : rd_mid;
  end

endmodule

// File: rtl/code_group_tx.sv
// PCS transmit ordered-set generator: idles, /S/ data /T/ /R/ framing, 8b/10b encoding, one group per cycle.
// TXD is captured one cycle ahead so /S/ can replace the first octet of a frame that starts on an even slot.
module code_group_tx
  import code_group_tx_pkg::*;
(
  input  logic       Clk,
  input  logic       mr_main_reset,
  input  logic       power_on,
  input  logic       TX_EN,
  input  logic [7:0] TXD,
  output logic [9:0] tx_code_group,
  output logic       tx_even,
  output logic       transmitting,
  output logic       tx_disparity
);

  tx_state_t  state;
  logic [7:0] txd_q;
  logic       sync_rst;
  logic       slot_even;
  cg_sym_t    sym;
  logic [9:0] enc_code;
  logic       enc_rd;

  assign sync_rst  = mr_main_reset | power_on;
  // The slot being produced now: IDLE_EVEN re-anchors parity, everything else alternates.
  assign slot_even = (state == IDLE_EVEN) | ~tx_even;

  always_comb begin
    sym = SYM_K28_5;
    case (state)
      IDLE_EVEN: sym = SYM_K28_5;
      IDLE_ODD:  sym = tx_disparity ? SYM_D16_2 : SYM_D5_6;
      SOP:       sym = SYM_K27_7;
      DATA:      sym = '{k: 1'b0, octet: txd_q};
      EPD_T:     sym = SYM_K29_7;
      EPD_R1:    sym = SYM_K23_7;
      EPD_R2:    sym = SYM_K23_7;
      default:   sym = SYM_K28_5;
    endcase
  end

  enc_8b10b u_enc (
    .octet  (sym.octet),
    .k      (sym.k),
    .rd_in  (tx_disparity),
    .code   (enc_code),
    .rd_out (enc_rd)
  );

  // NOTE: non-blocking assignments throughout, so every register samples the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (sync_rst) begin
      state         <= IDLE_EVEN;
      txd_q         <= 8'h00;
      tx_code_group <= CG_K28_5_NEG;
      tx_even       <= 1'b0;
      transmitting  <= 1'b0;
      tx_disparity  <= 1'b0;
    end else begin
      if (TX_EN)
        txd_q <= TXD;
      tx_code_group <= enc_code;
      tx_disparity  <= enc_rd;
      tx_even       <= slot_even;
      transmitting  <= (state == SOP) || (state == DATA);

      case (state)
        IDLE_EVEN: state <= IDLE_ODD;
        IDLE_ODD:  state <= TX_EN ? SOP : IDLE_EVEN;
        SOP:       state <= TX_EN ? DATA : EPD_T;
        DATA:      state <= TX_EN ? DATA : EPD_T;
        EPD_T:     state <= EPD_R1;
        // A second /R/ is needed only when the first lands on an even slot.
        EPD_R1:    state <= slot_even ? EPD_R2 : IDLE_EVEN;
        EPD_R2:    state <= IDLE_EVEN;
        default:   state <= IDLE_EVEN;
      endcase
    end
  end

endmodule

// File: tb/tb_code_group_tx.sv
// Directed bench for code_group_tx: each slot applies TX_EN/TXD, clocks once and checks all four outputs.
// Expected groups are hand-encoded 8b/10b values (abcdei fghj).
module tb_code_group_tx;

  logic       Clk = 1'b0;
  logic       mr_main_reset;
  logic       power_on;
  logic       TX_EN;
  logic [7:0] TXD;
  logic [9:0] tx_code_group;
  logic       tx_even;
  logic       transmitting;
  logic       tx_disparity;

  int checks   = 0;
  int failures = 0;

  localparam logic [9:0] K28_N  = 10'b0011111010;
  localparam logic [9:0] K28_P  = 10'b1100000101;
  localparam logic [9:0] D162_P = 10'b1001000101;
  localparam logic [9:0] D162_N = 10'b0110110101;
  localparam logic [9:0] D56    = 10'b1010010110;
  localparam logic [9:0] D212   = 10'b1010100101;
  localparam logic [9:0] D216   = 10'b1010100110;
  localparam logic [9:0] K277_N = 10'b1101101000;
  localparam logic [9:0] K297_N = 10'b1011101000;
  localparam logic [9:0] K297_P = 10'b0100010111;
  localparam logic [9:0] K237_N = 10'b1110101000;
  localparam logic [9:0] K237_P = 10'b0001010111;

  code_group_tx dut (
    .Clk           (Clk),
    .mr_main_reset (mr_main_reset),
    .power_on      (power_on),
    .TX_EN         (TX_EN),
    .TXD           (TXD),
    .tx_code_group (tx_code_group),
    .tx_even       (tx_even),
    .transmitting  (transmitting),
    .tx_disparity  (tx_disparity)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [9:0] actual, input logic [9:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  task automatic slot(input string tag, input logic en, input logic [7:0] d,
                      input logic [9:0] cg, input logic ev, input logic tr, input logic rd);
    TX_EN = en;
    TXD   = d;
    @(posedge Clk);
    #1;
    check({tag, ".cg"},   tx_code_group,         cg);
    check({tag, ".even"}, {9'b0, tx_even},       {9'b0, ev});
    check({tag, ".tx"},   {9'b0, transmitting},  {9'b0, tr});
    check({tag, ".rd"},   {9'b0, tx_disparity},  {9'b0, rd});
  endtask

  initial begin
    mr_main_reset = 1'b1;
    power_on      = 1'b0;
    TX_EN         = 1'b0;
    TXD           = 8'h00;

    slot("reset", 1'b0, 8'h00, K28_N, 1'b0, 1'b0, 1'b0);
    mr_main_reset = 1'b0;

    // Idle: /I2/ repeating from RD-, first K28.5 on an even slot.
    for (int i = 0; i < 3; i++) begin
      slot("idle_k", 1'b0, 8'h00, K28_N,  1'b1, 1'b0, 1'b1);
      slot("idle_d", 1'b0, 8'h00, D162_P, 1'b0, 1'b0, 1'b0);
    end

    // Frame A: TX_EN rises for an even slot; /S/ replaces the first 0x55; three data slots end at RD+.
    slot("a_i0", 1'b0, 8'h00, K28_N,  1'b1, 1'b0, 1'b1);
    slot("a_i1", 1'b1, 8'h55, D162_P, 1'b0, 1'b0, 1'b0);
    slot("a_s",  1'b1, 8'h55, K277_N, 1'b1, 1'b1, 1'b0);
    slot("a_d0", 1'b1, 8'hD5, D212,   1'b0, 1'b1, 1'b0);
    slot("a_d1", 1'b1, 8'h50, D216,   1'b1, 1'b1, 1'b0);
    slot("a_d2", 1'b0, 8'hFF, D162_N, 1'b0, 1'b1, 1'b1);
    slot("a_t",  1'b0, 8'hFF, K297_P, 1'b1, 1'b0, 1'b1);
    slot("a_r",  1'b0, 8'h00, K237_P, 1'b0, 1'b0, 1'b1);
    slot("a_k",  1'b0, 8'h00, K28_P,  1'b1, 1'b0, 1'b0);
    slot("a_i",  1'b0, 8'h00, D56,    1'b0, 1'b0, 1'b0);

    // Frame B: TX_EN rises for an odd slot; /I/ completes, first octet dropped, two data slots.
    slot("b_i0", 1'b1, 8'h55, K28_N,  1'b1, 1'b0, 1'b1);
    slot("b_i1", 1'b1, 8'h55, D162_P, 1'b0, 1'b0, 1'b0);
    slot("b_s",  1'b1, 8'hD5, K277_N, 1'b1, 1'b1, 1'b0);
    slot("b_d0", 1'b1, 8'h55, D216,   1'b0, 1'b1, 1'b0);
    slot("b_d1", 1'b0, 8'hAA, D212,   1'b1, 1'b1, 1'b0);
    // TX_EN high during /T/ /R/ /R/ must not restart the frame early.
    slot("b_t",  1'b1, 8'h55, K297_N, 1'b0, 1'b0, 1'b0);
    slot("b_r1", 1'b1, 8'h55, K237_N, 1'b1, 1'b0, 1'b0);
    slot("b_r2", 1'b1, 8'h55, K237_N, 1'b0, 1'b0, 1'b0);
    slot("b_k",  1'b1, 8'h55, K28_N,  1'b1, 1'b0, 1'b1);

    // Frame C aborted by mr_main_reset in DATA.
    slot("c_i1", 1'b1, 8'h55, D162_P, 1'b0, 1'b0, 1'b0);
    slot("c_s",  1'b1, 8'h50, K277_N, 1'b1, 1'b1, 1'b0);
    slot("c_d0", 1'b1, 8'h55, D162_N, 1'b0, 1'b1, 1'b1);
    mr_main_reset = 1'b1;
    slot("c_rst", 1'b1, 8'h55, K28_N, 1'b0, 1'b0, 1'b0);
    mr_main_reset = 1'b0;
    slot("c_k",  1'b1, 8'h55, K28_N,  1'b1, 1'b0, 1'b1);
    slot("c_i",  1'b0, 8'h00, D162_P, 1'b0, 1'b0, 1'b0);

    // power_on acts like mr_main_reset.
    power_on = 1'b1;
    slot("p_rst", 1'b0, 8'h00, K28_N, 1'b0, 1'b0, 1'b0);
    power_on = 1'b0;
    slot("p_k",  1'b0, 8'h00, K28_N,  1'b1, 1'b0, 1'b1);

    // Frame D: single octet replaced by /S/, zero data slots -> /T/ /R/ /R/.
    slot("d_i1", 1'b1, 8'h55, D162_P, 1'b0, 1'b0, 1'b0);
    slot("d_s",  1'b0, 8'h00, K277_N, 1'b1, 1'b1, 1'b0);
    slot("d_t",  1'b0, 8'h00, K297_N, 1'b0, 1'b0, 1'b0);
    slot("d_r1", 1'b0, 8'h00, K237_N, 1'b1, 1'b0, 1'b0);
    slot("d_r2", 1'b0, 8'h00, K237_N, 1'b0, 1'b0, 1'b0);
    slot("d_k",  1'b0, 8'h00, K28_N,  1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_group_tx.md
CODE_GROUP_TX -- requirements
Module: code_group_tx

Interface
REQ-001 SHALL have no parameters; all code-group constants come from the shared package.
REQ-002 SHALL have port Clk  input  1  rising-edge clock, one code group per cycle.
REQ-003 SHALL have port mr_main_reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port power_on  input  1  synchronous, active-high; same effect as mr_main_reset.
REQ-005 SHALL have port TX_EN  input  1  frame-valid from the MAC side.
REQ-006 SHALL have port TXD  input  8  frame octet, valid while TX_EN=1.
REQ-007 SHALL have port tx_code_group  output  10  registered code group, bit 9 = a ... bit 0 = j (abcdei fghj).
REQ-008 SHALL have port tx_even  output  1  high when the current tx_code_group occupies an even slot.
REQ-009 SHALL have port transmitting  output  1  high from the /S/ slot through the last data slot.
REQ-010 SHALL have port tx_disparity  output  1  running disparity after the current code group (1 = RD+).

Function
REQ-011 SHALL register every output; latency is 1 cycle (inputs sampled at edge n drive the outputs after edge n+1).
REQ-012 SHALL toggle tx_even every cycle, except that the slot after the final /R/ is always even.
REQ-013 SHALL implement states IDLE_EVEN, IDLE_ODD, SOP, DATA, EPD_T, EPD_R1, EPD_R2.
REQ-014 SHALL behave as follows in IDLE_EVEN and IDLE_ODD:
- IDLE_EVEN emits K28.5 and always goes to IDLE_ODD.
- IDLE_ODD emits D16.2 if RD was negative before the preceding K28.5 (/I2/), else D5.6 (/I1/).
REQ-015 SHALL leave IDLE_ODD to SOP if TX_EN=1, else to IDLE_EVEN.
REQ-016 SHALL make TX_EN rising while the next slot is odd complete the /I/, drop that first TXD octet, and place /S/ in the following even slot.
REQ-017 SHALL handle SOP as follows:
- Emits K27.7 (/S/) in place of the sampled TXD octet.
- Goes to DATA if TX_EN=1, else to EPD_T.
REQ-018 SHALL handle DATA as follows:
- Emits D-code of TXD.
- Stays while TX_EN=1; goes to EPD_T on TX_EN=0.
REQ-019 SHALL make EPD_T emit K29.7 (/T/) and go to EPD_R1.
REQ-020 SHALL make EPD_R1 emit K23.7 (/R/), then go to EPD_R2 if this slot is even, else to IDLE_EVEN.
REQ-021 SHALL make EPD_R2 emit K23.7 and go to IDLE_EVEN.
REQ-022 SHALL ignore TX_EN in EPD_T, EPD_R1 and EPD_R2; a new frame starts no earlier than the next IDLE_ODD.
REQ-023 SHALL ignore TXD whenever TX_EN=0.
REQ-024 SHALL encode every code group with 8b/10b using the current RD and update RD per 8b/10b rules each cycle.
REQ-025 SHALL place a comma (K28.5) only in even slots.

Reset
REQ-026 SHALL, while mr_main_reset or power_on is high at a clock edge, force all of the following:
- state = IDLE_EVEN
- RD = negative
- tx_code_group = 10'b0011111010 (K28.5 RD-)
- tx_even = 0, transmitting = 0, tx_disparity = 0
REQ-027 SHALL emit K28.5 with tx_even=1 in the first slot after reset release.
REQ-028 SHALL make reset mid-frame abort the frame without /T/ or /R/.

Structure
REQ-029 SHALL take the following from the shared package:
- K28.5, K27.7, K29.7 and K23.7 octet values and control flags
- D16.2 and D5.6 octet values
- State encodings
REQ-030 SHALL instantiate one combinational sub-module, enc_8b10b (inputs: octet, K flag, RD; outputs: 10-bit group, new RD), also usable by the receive-side bench.

Verification
REQ-031 SHALL check idle after reset: hold TX_EN=0 for 6 cycles -> 0011111010, 1001000101 repeating, with tx_even 1,0,1,0...
REQ-032 SHALL check frame alignment: TX_EN rises on the even boundary with TXD 0x55,0x55,0xD5 -> K27.7 replaces 0x55, and transmitting=1 from the /S/ slot.
REQ-033 SHALL check odd-boundary start: TX_EN rises while the next slot is odd -> D16.2 is sent, the first octet is dropped, and /S/ is sent on an even slot.
REQ-034 SHALL check the end of frame:
- Odd data count -> /T/ then a single /R/.
- Even data count -> /T/, /R/, /R/.
- In both cases the next K28.5 has tx_even=1.
REQ-035 SHALL check the post-frame idle: frame ending at RD+ -> first idle is K28.5 RD+ (1100000101) followed by D5.6.
REQ-036 SHALL check reset mid-DATA: reset -> next cycle 0011111010, transmitting=0, tx_disparity=0.
